// File: rtl/jtcps1_dwnld_sched_pkg.sv
// jtcps1_dwnld_sched_pkg: shared FSM states, lane mask encodings and byte lane placement
package jtcps1_dwnld_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;
  localparam logic [1:0] MASK_W  = 2'b00;
  function automatic logic [15:0] lane_data(input logic [7:0] b, input logic [1:0] m);
    return m == MASK_HI ? {b, 8'h00} : m == MASK_LO ? {8'h00, b} : 16'h0000;
  endfunction
endpackage

// File: rtl/jtcps1_dwnld_sched_if.sv
// jtcps1_dwnld_sched_if: loader byte stream and SDRAM write port of the download scheduler
interface jtcps1_dwnld_sched_if #(parameter int AW = 22);
  logic          downloading, in_we, ioctl_wait, sdram_we, sdram_ack, dwnld_done, overflow;
  logic [AW-1:0] in_addr, sdram_addr;
  logic [7:0]    in_data;
  logic [1:0]    in_mask, in_bank, sdram_mask, sdram_bank;
  logic [15:0]   sdram_data;
  modport slave (
    input  downloading, in_we, in_addr, in_data, in_mask, in_bank, sdram_ack,
    output ioctl_wait, sdram_addr, sdram_data, sdram_mask, sdram_bank, sdram_we, dwnld_done, overflow
  );
  modport master (
    output downloading, in_we, in_addr, in_data, in_mask, in_bank, sdram_ack,
    input  ioctl_wait, sdram_addr, sdram_data, sdram_mask, sdram_bank, sdram_we, dwnld_done, overflow
  );
endinterface

// File: rtl/jtcps1_dwnld_sched_fifo.sv
// jtcps1_dwnld_sched_fifo: small synchronous FIFO, push on full only when popping the same cycle
module jtcps1_dwnld_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(do_push);
      rd_q  <= rd_q + PW'(do_pop);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  // storage needs no reset, occupancy is tracked by the count
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/jtcps1_dwnld_sched.sv
// jtcps1_dwnld_sched: merges loader bytes into 16-bit words and schedules SDRAM writes
module jtcps1_dwnld_sched
  import jtcps1_dwnld_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 22
) (
  input logic                 clk,
  input logic                 rst,
  jtcps1_dwnld_sched_if.slave bus
);
  localparam int W  = AW + 20;
  localparam int CW = $clog2(DEPTH) + 1;
  state_t        state_q, state_d;
  logic          pv_q, pv_d, ovf_q, ovf_d, we_q, push, pop, full, empty, merge, room, take;
  logic [AW-1:0] pa_q, pa_d;
  logic [1:0]    pb_q, pb_d, pm_q, pm_d;
  logic [15:0]   pd_q, pd_d, lane;
  logic [W-1:0]  din, dout, out_q;
  logic [CW-1:0] count;
  assign lane  = lane_data(bus.in_data, bus.in_mask);
  assign merge = pv_q && bus.in_addr == pa_q && bus.in_bank == pb_q && bus.in_mask != pm_q;
  assign pop   = we_q && bus.sdram_ack;
  assign room  = !full || pop;
  assign take  = state_q == LOAD && bus.in_we;
  jtcps1_dwnld_sched_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(din),
    .dout_o(dout), .count_o(count), .full_o(full), .empty_o(empty)
  );
  // control FSM plus pending-slot merge; a byte needing a push into a full FIFO is dropped
  always_comb begin
    state_d = state_q;
    pv_d    = pv_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pd_d    = pd_q;
    pm_d    = pm_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    din     = {pa_q, pb_q, pd_q, pm_q};
    case (state_q)
      IDLE, DONE: state_d = bus.downloading ? LOAD : state_q;
      LOAD:       state_d = bus.downloading ? LOAD : FLUSH;
      default:    state_d = (!pv_q && empty && !we_q) ? DONE : FLUSH;
    endcase
    if (take && pv_q && !room) ovf_d = 1'b1;
    else if (take && merge) begin
      push = 1'b1;
      din  = {pa_q, pb_q, pd_q | lane, MASK_W};
      pv_d = 1'b0;
    end else if (take) begin
      push = pv_q;
      pv_d = 1'b1;
      pa_d = bus.in_addr;
      pb_d = bus.in_bank;
      pd_d = lane;
      pm_d = bus.in_mask;
    end
    if (state_q == FLUSH && pv_q && room) begin
      push = 1'b1;
      pv_d = 1'b0;
    end
  end
  // FSM, pending slot and sticky overflow registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pv_q    <= 1'b0;
      pa_q    <= '0;
      pb_q    <= '0;
      pd_q    <= '0;
      pm_q    <= 2'b11;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pd_q    <= pd_d;
      pm_q    <= pm_d;
      ovf_q   <= ovf_d;
    end
  // hold the FIFO head on the bus until acked, then drop we for one cycle before the next word
  always_ff @(posedge clk)
    if (rst) begin
      we_q  <= 1'b0;
      out_q <= W'(2'b11);
    end else begin
      we_q <= we_q ? !bus.sdram_ack : !empty;
      if (!we_q && !empty) out_q <= dout;
    end
  assign {bus.sdram_addr, bus.sdram_bank, bus.sdram_data, bus.sdram_mask} = out_q;
  assign bus.sdram_we   = we_q;
  assign bus.ioctl_wait = count >= CW'(DEPTH - 1) || state_q == FLUSH;
  assign bus.dwnld_done = state_q == DONE;
  assign bus.overflow   = ovf_q;
endmodule
